// File: rtl/mc_pkg.sv
// Multicycle controller shared types: state enum, opcode constants,
// datapath select encodings and the packed control-word payload.
package mc_pkg;

  localparam int unsigned RETIRED_W = 32;
  localparam int unsigned OPCODE_W  = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB_ALU,
    ST_ADDR,
    ST_MEM,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JAL,
    ST_TRAP
  } mc_state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_RS1  = 1'b1;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic PCSRC_ALU    = 1'b0;
  localparam logic PCSRC_ALUOUT = 1'b1;
  localparam logic ADDR_PC      = 1'b0;
  localparam logic ADDR_ALUOUT  = 1'b1;

  // Control word driven to the datapath each cycle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_we;
    logic       ir_we;
    logic       mdr_we;
    logic       aluout_we;
    logic       reg_we;
    logic       pc_src;
    logic [1:0] wb_sel;
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       trap;
  } mc_ctl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mc_ctrl_if;
  import mc_pkg::*;

  logic                      run;
  logic [OPCODE_W-1:0]       opcode;
  logic                      br_taken;
  logic                      mem_ready;
  logic                      mem_req;
  logic                      mem_we;
  logic                      addr_sel;
  logic                      pc_we;
  logic                      ir_we;
  logic                      mdr_we;
  logic                      aluout_we;
  logic                      reg_we;
  logic                      pc_src;
  logic [1:0]                wb_sel;
  logic [1:0]                alu_op;
  logic                      src_a;
  logic [1:0]                src_b;
  logic                      trap;
  logic                      bus_err;
  logic [RETIRED_W-1:0]      retired;

  modport master (
    input  run, opcode, br_taken, mem_ready,
    output mem_req, mem_we, addr_sel, pc_we, ir_we, mdr_we, aluout_we, reg_we,
           pc_src, wb_sel, alu_op, src_a, src_b, trap, bus_err, retired
  );

  modport slave (
    output run, opcode, br_taken, mem_ready,
    input  mem_req, mem_we, addr_sel, pc_we, ir_we, mdr_we, aluout_we, reg_we,
           pc_src, wb_sel, alu_op, src_a, src_b, trap, bus_err, retired
  );
endinterface

// File: rtl/mc_mem_timer.sv
// Counts consecutive memory wait cycles; flags the cycle that reaches the limit.
module mc_mem_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_expire_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Wait-cycle counter: any non-wait cycle (ready or state exit) clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_wait) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = i_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV-style control FSM. Optional memory timeout via MC_CTRL_MEM_TIMEOUT_EN.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  mc_ctrl_if.master   bus
);
  mc_state_e            r_state;
  mc_state_e            w_next;
  mc_ctl_t              w_ctl;
  logic                 w_retire;
  logic                 w_expire;
  logic [RETIRED_W-1:0] r_retired;

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  logic w_wait;
  logic r_bus_err;

  assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ready;

  mc_mem_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wait     (w_wait),
    .o_expire_c (w_expire)
  );

  // Sticky bus error, set on the timeout cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else if (w_expire) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus.bus_err = r_bus_err;
`else
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = 32'(TIMEOUT_CYCLES);
  assign w_expire     = 1'b0;
  assign bus.bus_err  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + RETIRED_W'(1);
    end
  end

  // Next state and control word
  always_comb begin
    w_next   = r_state;
    w_ctl    = '0;
    w_retire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_ctl.mem_req  = 1'b1;
        w_ctl.addr_sel = ADDR_PC;
        w_ctl.alu_op   = ALU_ADD;
        w_ctl.src_a    = SRCA_PC;
        w_ctl.src_b    = SRCB_FOUR;
        if (bus.mem_ready) begin
          w_ctl.ir_we  = 1'b1;
          w_ctl.pc_we  = 1'b1;
          w_ctl.pc_src = PCSRC_ALU;
          w_next       = ST_DECODE;
        end else if (w_expire) begin
          w_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.src_a     = SRCA_PC;
        w_ctl.src_b     = SRCB_IMM;
        w_ctl.aluout_we = 1'b1;
        case (bus.opcode)
          OP_RTYPE, OP_ITYPE: w_next = ST_EXEC;
          OP_LOAD, OP_STORE:  w_next = ST_ADDR;
          OP_BRANCH:          w_next = ST_BRANCH;
          OP_JAL:             w_next = ST_JAL;
          default:            w_next = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        w_ctl.alu_op    = ALU_FUNCT;
        w_ctl.src_a     = SRCA_RS1;
        w_ctl.src_b     = (bus.opcode == OP_RTYPE) ? SRCB_RS2 : SRCB_IMM;
        w_ctl.aluout_we = 1'b1;
        w_next          = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        w_ctl.reg_we = 1'b1;
        w_ctl.wb_sel = WB_ALUOUT;
        w_retire     = 1'b1;
      end
      ST_ADDR: begin
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.src_a     = SRCA_RS1;
        w_ctl.src_b     = SRCB_IMM;
        w_ctl.aluout_we = 1'b1;
        w_next          = ST_MEM;
      end
      ST_MEM: begin
        w_ctl.mem_req  = 1'b1;
        w_ctl.addr_sel = ADDR_ALUOUT;
        w_ctl.mem_we   = (bus.opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_STORE) begin
            w_retire = 1'b1;
          end else begin
            w_ctl.mdr_we = 1'b1;
            w_next       = ST_WB_MEM;
          end
        end else if (w_expire) begin
          w_next = ST_TRAP;
        end
      end
      ST_WB_MEM: begin
        w_ctl.reg_we = 1'b1;
        w_ctl.wb_sel = WB_MDR;
        w_retire     = 1'b1;
      end
      ST_BRANCH: begin
        w_ctl.alu_op = ALU_BR;
        w_ctl.src_a  = SRCA_RS1;
        w_ctl.src_b  = SRCB_RS2;
        w_ctl.pc_src = PCSRC_ALUOUT;
        w_ctl.pc_we  = bus.br_taken;
        w_retire     = 1'b1;
      end
      ST_JAL: begin
        w_ctl.pc_we  = 1'b1;
        w_ctl.pc_src = PCSRC_ALUOUT;
        w_ctl.reg_we = 1'b1;
        w_ctl.wb_sel = WB_PC;
        w_retire     = 1'b1;
      end
      ST_TRAP: begin
        w_ctl.trap = 1'b1;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // Instruction boundary: continue or park depending on run
    if (w_retire) w_next = bus.run ? ST_FETCH : ST_IDLE;
  end

  assign bus.mem_req   = w_ctl.mem_req;
  assign bus.mem_we    = w_ctl.mem_we;
  assign bus.addr_sel  = w_ctl.addr_sel;
  assign bus.pc_we     = w_ctl.pc_we;
  assign bus.ir_we     = w_ctl.ir_we;
  assign bus.mdr_we    = w_ctl.mdr_we;
  assign bus.aluout_we = w_ctl.aluout_we;
  assign bus.reg_we    = w_ctl.reg_we;
  assign bus.pc_src    = w_ctl.pc_src;
  assign bus.wb_sel    = w_ctl.wb_sel;
  assign bus.alu_op    = w_ctl.alu_op;
  assign bus.src_a     = w_ctl.src_a;
  assign bus.src_b     = w_ctl.src_b;
  assign bus.trap      = w_ctl.trap;
  assign bus.retired   = r_retired;
endmodule
